// File: rtl/program_feeder_if.sv
// Bus bundle between the program feeder and its controller / processor side.
// The feeder uses the slave modport; the driving environment uses master.
interface program_feeder_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          Load_En;
    logic [AW-1:0] Load_Addr;
    logic [9:0]    Load_Data;
    logic [AW:0]   Prog_Len;
    logic          Start;
    logic          Done_In;
    logic [9:0]    Data_Out;
    logic          Step_Clock;
    logic          Busy;
    logic          Finished;
    logic          Error;
    logic [AW-1:0] PC;
    logic [AW:0]   Instr_Count;

    modport master (
        output Load_En, Load_Addr, Load_Data, Prog_Len, Start, Done_In,
        input  Data_Out, Step_Clock, Busy, Finished, Error, PC, Instr_Count
    );

    modport slave (
        input  Load_En, Load_Addr, Load_Data, Prog_Len, Start, Done_In,
        output Data_Out, Step_Clock, Busy, Finished, Error, PC, Instr_Count
    );
endinterface

// File: rtl/program_feeder.sv
// Program feeder: presents stored words to the processor's switch inputs and
// generates fixed-width clock pulses, advancing when the processor reports Done.
module program_feeder #(
    parameter int DEPTH        = 16,
    parameter int PULSE_CYCLES = 1000,
    parameter int GAP_CYCLES   = 1000,
    parameter int MAX_STEPS    = 3
) (
    input logic            Clock_50MHz,
    input logic            Reset,
    program_feeder_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(MAX_STEPS + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_DECIDE, S_FINISHED, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] step_q, step_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   icount_q, icount_d;
    logic [9:0]    data_q, data_d;
    logic          done_seen_q, done_seen_d;
    logic          step_clock_q, step_clock_d;
    logic          busy_q, busy_d;
    logic          finished_q, finished_d;
    logic          error_q, error_d;

    logic [9:0]    mem [DEPTH];

    logic [AW-1:0] pc_inc;
    logic [AW:0]   pc_inc_ext;
    logic [SW-1:0] step_inc;
    logic          is_ld;

    // Writes only land while no run is in progress; contents survive reset.
    always_ff @(posedge Clock_50MHz) begin
        if (bus.Load_En && !busy_q)
            mem[bus.Load_Addr] <= bus.Load_Data;
    end

    assign pc_inc     = pc_q + 1'b1;
    assign pc_inc_ext = {1'b0, pc_q} + 1'b1;
    assign step_inc   = step_q + 1'b1;
    assign is_ld      = (data_q[9:8] == 2'b00) && (data_q[3:0] == 4'h0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        len_d       = len_q;
        pc_d        = pc_q;
        icount_d    = icount_q;
        data_d      = data_q;
        done_seen_d = done_seen_q;

        case (state_q)
            S_IDLE, S_FINISHED, S_ERROR: begin
                if (bus.Start) begin
                    pc_d     = '0;
                    icount_d = '0;
                    step_d   = '0;
                    cnt_d    = '0;
                    if (bus.Prog_Len == '0) begin
                        state_d = S_FINISHED;
                    end else begin
                        len_d   = (bus.Prog_Len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.Prog_Len;
                        data_d  = mem[0];
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d       = '0;
                    done_seen_d = (step_q == '0) ? 1'b0 : bus.Done_In;
                    state_d     = S_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECIDE: begin
                // A load word at T0 pulls in its data word before Done is considered.
                if (step_q == '0 && is_ld) begin
                    if (pc_inc_ext >= len_q) begin
                        state_d = S_ERROR;
                    end else begin
                        pc_d    = pc_inc;
                        data_d  = mem[pc_inc];
                        step_d  = SW'(1);
                        state_d = S_SETUP;
                    end
                end else if (done_seen_q) begin
                    icount_d = icount_q + 1'b1;
                    pc_d     = pc_inc;
                    if (pc_inc_ext == len_q) begin
                        state_d = S_FINISHED;
                    end else begin
                        data_d  = mem[pc_inc];
                        step_d  = '0;
                        state_d = S_SETUP;
                    end
                end else begin
                    step_d  = step_inc;
                    state_d = (step_inc > SW'(MAX_STEPS)) ? S_ERROR : S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        step_clock_d = (state_d == S_HIGH);
        busy_d       = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_DECIDE);
        finished_d   = (state_d == S_FINISHED);
        error_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge Clock_50MHz or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            step_q       <= '0;
            len_q        <= '0;
            pc_q         <= '0;
            icount_q     <= '0;
            data_q       <= '0;
            done_seen_q  <= 1'b0;
            step_clock_q <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            len_q        <= len_d;
            pc_q         <= pc_d;
            icount_q     <= icount_d;
            data_q       <= data_d;
            done_seen_q  <= done_seen_d;
            step_clock_q <= step_clock_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            error_q      <= error_d;
        end
    end

    assign bus.Data_Out    = data_q;
    assign bus.Step_Clock  = step_clock_q;
    assign bus.Busy        = busy_q;
    assign bus.Finished    = finished_q;
    assign bus.Error       = error_q;
    assign bus.PC          = pc_q;
    assign bus.Instr_Count = icount_q;
endmodule

// File: tb/tb_program_feeder.sv
// Testbench for program_feeder: a small processor model answers Done, and a
// pulse scoreboard checks the word presented on every Step_Clock pulse.
module tb_program_feeder;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PULSE = 3;
    localparam int GAP   = 2;
    localparam int MAXS  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    program_feeder_if #(.DEPTH(DEPTH)) bus ();

    program_feeder #(
        .DEPTH(DEPTH),
        .PULSE_CYCLES(PULSE),
        .GAP_CYCLES(GAP),
        .MAX_STEPS(MAXS)
    ) dut (
        .Clock_50MHz(clk),
        .Reset(rst),
        .bus(bus)
    );

    // Processor timestep model: advances per pulse, returns to T0 after a pulse with Done high.
    int   ts;
    int   done_at;
    logic model_rst;
    always @(posedge bus.Step_Clock or posedge model_rst) begin
        if (model_rst)        ts <= 0;
        else if (bus.Done_In) ts <= 0;
        else                  ts <= ts + 1;
    end
    assign bus.Done_In = (ts == done_at);

    logic [9:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic model_reset(input int d);
        done_at   = d;
        model_rst = 1'b1;
        #1 model_rst = 1'b0;
    endtask

    task automatic load_word(input int a, input logic [9:0] d);
        @(negedge clk);
        bus.Load_En   = 1'b1;
        bus.Load_Addr = a[AW-1:0];
        bus.Load_Data = d;
        @(negedge clk);
        bus.Load_En   = 1'b0;
    endtask

    task automatic start_run(input int len);
        @(negedge clk);
        bus.Prog_Len = len[AW:0];
        bus.Start    = 1'b1;
        @(negedge clk);
        bus.Start    = 1'b0;
    endtask

    task automatic push_n(input logic [9:0] w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(w);
    endtask

    // Watches pulses until the run ends; optionally attempts a write to mem[0] mid-run.
    task automatic run_and_collect(input string name, input int exp_pulses, input bit do_load);
        int pulses = 0;
        int width  = 0;
        int low    = 0;
        int cyc    = 0;
        logic prev = 1'b0;
        logic [9:0] held = '0;
        logic [9:0] exp;
        bus.Load_Addr = '0;
        bus.Load_Data = 10'h3FF;
        while (cyc < 2000) begin
            if (bus.Step_Clock && !prev) begin
                checks++;
                if (low !== ((pulses == 0) ? GAP : GAP + 1)) begin
                    errors++;
                    $display("FAIL %s gap: pulse %0d low cycles %0d, required %0d", name, pulses, low, (pulses == 0) ? GAP : GAP + 1);
                end
                pulses++;
                width = 1;
                held  = bus.Data_Out;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_pulse: pulse %0d with Data_Out %h, required no pulse", name, pulses, held);
                end else begin
                    exp = exp_q.pop_front();
                    if (held !== exp) begin
                        errors++;
                        $display("FAIL %s pulse_data: pulse %0d Data_Out %h, required %h", name, pulses, held, exp);
                    end
                end
            end else if (bus.Step_Clock) begin
                width++;
                checks++;
                if (bus.Data_Out !== held) begin
                    errors++;
                    $display("FAIL %s data_stable: Data_Out %h, required %h", name, bus.Data_Out, held);
                end
            end else if (prev) begin
                low = 1;
                checks++;
                if (width !== PULSE) begin
                    errors++;
                    $display("FAIL %s pulse_width: width %0d, required %0d", name, width, PULSE);
                end
            end else begin
                low++;
            end
            prev = bus.Step_Clock;
            if (!bus.Busy && !bus.Step_Clock) break;
            bus.Load_En = do_load && (cyc == 2);
            @(negedge clk);
            cyc++;
        end
        bus.Load_En = 1'b0;
        checks++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL %s timeout: still busy after %0d cycles, required completion", name, cyc);
        end
        checks++;
        if (pulses !== exp_pulses) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d, required %0d", name, pulses, exp_pulses);
        end
        exp_q.delete();
    endtask

    task automatic check_status(input string name, input logic fin, input logic err, input int pc, input int cnt);
        checks++;
        if (bus.Finished !== fin) begin
            errors++;
            $display("FAIL %s finished: got %b, required %b", name, bus.Finished, fin);
        end
        checks++;
        if (bus.Error !== err) begin
            errors++;
            $display("FAIL %s error: got %b, required %b", name, bus.Error, err);
        end
        checks++;
        if (bus.PC !== pc[AW-1:0]) begin
            errors++;
            $display("FAIL %s pc: got %0d, required %0d", name, bus.PC, pc);
        end
        checks++;
        if (bus.Instr_Count !== cnt[AW:0]) begin
            errors++;
            $display("FAIL %s instr_count: got %0d, required %0d", name, bus.Instr_Count, cnt);
        end
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got %b, required 0", name, bus.Busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.Data_Out !== 10'h000 || bus.Step_Clock !== 1'b0) begin
            errors++;
            $display("FAIL reset_data_clk: Data_Out %h Step_Clock %b, required 000 0", bus.Data_Out, bus.Step_Clock);
        end
        check_status("reset", 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_ld_pair();
        load_word(0, 10'h000);
        load_word(1, 10'h155);
        model_reset(1);
        exp_q.push_back(10'h000);
        exp_q.push_back(10'h155);
        start_run(2);
        run_and_collect("ld_pair", 2, 1'b0);
        check_status("ld_pair", 1'b1, 1'b0, 2, 1);
    endtask

    task automatic test_multi_step();
        load_word(0, 10'h042);
        model_reset(3);
        push_n(10'h042, 4);
        start_run(1);
        run_and_collect("multi_step", 4, 1'b0);
        check_status("multi_step", 1'b1, 1'b0, 1, 1);
    endtask

    task automatic test_hang();
        model_reset(99);
        push_n(10'h042, 4);
        start_run(1);
        run_and_collect("hang", 4, 1'b0);
        check_status("hang", 1'b0, 1'b1, 0, 0);
        repeat (2 * (GAP + PULSE)) @(negedge clk);
        checks++;
        if (bus.Step_Clock !== 1'b0 || bus.Error !== 1'b1) begin
            errors++;
            $display("FAIL hang_hold: Step_Clock %b Error %b, required 0 1", bus.Step_Clock, bus.Error);
        end
    endtask

    task automatic test_truncated_ld();
        load_word(0, 10'h000);
        model_reset(99);
        exp_q.push_back(10'h000);
        start_run(1);
        run_and_collect("truncated_ld", 1, 1'b0);
        check_status("truncated_ld", 1'b0, 1'b1, 0, 0);
    endtask

    task automatic test_reset_mid_high();
        int n = 0;
        load_word(0, 10'h042);
        model_reset(3);
        start_run(1);
        while (!bus.Step_Clock && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.Step_Clock !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_high wait: Step_Clock %b, required 1", bus.Step_Clock);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.Step_Clock !== 1'b0 || bus.Busy !== 1'b0 || bus.Data_Out !== 10'h000) begin
            errors++;
            $display("FAIL reset_mid_high async: Step_Clock %b Busy %b Data_Out %h, required 0 0 000",
                     bus.Step_Clock, bus.Busy, bus.Data_Out);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset(3);
        push_n(10'h042, 4);
        start_run(1);
        run_and_collect("rerun_after_reset", 4, 1'b0);
        check_status("rerun_after_reset", 1'b1, 1'b0, 1, 1);
    endtask

    task automatic test_zero_len();
        start_run(0);
        checks++;
        if (bus.Finished !== 1'b1 || bus.Busy !== 1'b0 || bus.Step_Clock !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: Finished %b Busy %b Step_Clock %b, required 1 0 0",
                     bus.Finished, bus.Busy, bus.Step_Clock);
        end
        run_and_collect("zero_len", 0, 1'b0);
        check_status("zero_len", 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_load_while_busy();
        model_reset(3);
        push_n(10'h042, 4);
        start_run(1);
        run_and_collect("load_busy_run", 4, 1'b1);
        model_reset(3);
        push_n(10'h042, 4);
        start_run(1);
        run_and_collect("load_busy_rerun", 4, 1'b0);
        check_status("load_busy_rerun", 1'b1, 1'b0, 1, 1);
    endtask

    task automatic test_clamp();
        logic [9:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = 10'h001 | 10'(i << 4);
            load_word(i, w);
            push_n(w, 2);
        end
        model_reset(1);
        start_run(20);
        run_and_collect("clamp", 2 * DEPTH, 1'b0);
        check_status("clamp", 1'b1, 1'b0, 0, DEPTH);
    endtask

    initial begin
        rst           = 1'b1;
        bus.Load_En   = 1'b0;
        bus.Load_Addr = '0;
        bus.Load_Data = '0;
        bus.Prog_Len  = '0;
        bus.Start     = 1'b0;
        model_rst     = 1'b0;
        done_at       = 99;
        model_reset(99);
        test_reset();
        test_ld_pair();
        test_multi_step();
        test_hang();
        test_truncated_ld();
        test_reset_mid_high();
        test_zero_len();
        test_load_while_busy();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_feeder.md
Name: program_feeder

Overview:
- Automated stimulus source for the processor's external data/clock interface. It replaces the slide switches and the clock push-button.
- Holds a small loadable program memory and presents each word on the switch data lines. It then generates debounced-width clock pulses and watches the processor's Done output to decide when to advance.
- Sits at board top level:
  - Data_Out drives the processor's Raw_Data_From_Switches.
  - Step_Clock drives Clock_Button.
  - Done_In comes from LED_D_Done.

Parameters:
- DEPTH, 16: program memory words.
- AW, $clog2(DEPTH): address width (derived).
- PULSE_CYCLES, 1000: Step_Clock high time in Clock_50MHz cycles (≥1).
- GAP_CYCLES, 1000: Step_Clock low/setup time before each pulse (≥1).
- MAX_STEPS, 3: maximum timesteps after T0 before declaring a hang.

Ports:
- Clock_50MHz  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Load_En  in  1  write Load_Data to mem[Load_Addr] (IDLE/FINISHED/ERROR only).
- Load_Addr  in  AW  program memory write address.
- Load_Data  in  10  program word.
- Prog_Len  in  AW+1  number of words to run; sampled on Start.
- Start  in  1  single-cycle start strobe.
- Done_In  in  1  processor Done (Clr) level.
- Data_Out  out  10  word presented to the processor data input.
- Step_Clock  out  1  active-high pulse to the processor clock button input.
- Busy  out  1  run in progress.
- Finished  out  1  sticky: program completed.
- Error  out  1  sticky: hang or truncated ld.
- PC  out  AW  index of the word currently presented.
- Instr_Count  out  AW+1  instructions completed (ld+data pair counts 1).

Behaviour:
- One clock: Clock_50MHz. Reset is asynchronous, active-high.
- Reset values:
  - Data_Out=0, Step_Clock=0, Busy=0, Finished=0, Error=0, PC=0, Instr_Count=0.
  - FSM=IDLE, step counter=0.
  - Memory contents are not reset.
- Reset mid-operation forces Step_Clock low asynchronously, with no partial-pulse completion.
- Memory:
  - Synchronous write; combinational or registered read.
  - Data_Out is registered and must be stable for the whole SETUP+HIGH window.
- States: IDLE, SETUP, HIGH, DECIDE, FINISHED, ERROR. Busy=1 in SETUP/HIGH/DECIDE.
- IDLE/FINISHED/ERROR:
  - Load_En writes honoured; Load_En while Busy is ignored.
  - Start with Prog_Len=0 → FINISHED next cycle, no pulses.
  - Start with Prog_Len>DEPTH → length clamped to DEPTH.
  - Start otherwise → len latched, PC=0, step=0, Instr_Count=0, Finished=Error=0, Data_Out=mem[0], → SETUP.
  - Start while Busy is ignored.
- SETUP:
  - Step_Clock=0 for exactly GAP_CYCLES cycles.
  - On the last cycle, register done_seen=Done_In, forced to 0 when step=0.
  - → HIGH.
- HIGH: Step_Clock=1 for exactly PULSE_CYCLES cycles → DECIDE (one cycle, Step_Clock=0). DECIDE priority, highest first:
  1. step=0 and word is ld (Data_Out[9:8]=00 and Data_Out[3:0]=0000):
     - If PC+1 ≥ len → ERROR (truncated), PC unchanged.
     - Else PC=PC+1, Data_Out=mem[PC+1], step=1 → SETUP.
  2. done_seen=1:
     - Instr_Count+1, PC+1.
     - If new PC = len → FINISHED.
     - Else Data_Out=mem[new PC], step=0 → SETUP.
  3. Otherwise step+1:
     - If step+1 > MAX_STEPS → ERROR.
     - Else → SETUP.
- addi/subi (Data_Out[9]=1) are single-word; the word is held during all timesteps (immediate read from bus).
- FINISHED: Finished=1, Busy=0. ERROR: Error=1, Busy=0. Outputs hold until Start or Reset.
- Done_In is treated as a quasi-static level. It is sampled only at the end of SETUP; glitches elsewhere are ignored.
- Pulse count per instruction = 1 + (timestep index at which Done was seen). Minimum 2 pulses, maximum MAX_STEPS+1.

Test Plan:
- mem={0x000,0x155}, Prog_Len=2, Start; model asserts Done at T1 → exactly 2 pulses, each PULSE_CYCLES wide. Data_Out=0x000 during pulse 1 and 0x155 during pulse 2. Finished=1, Instr_Count=1, Error=0.
- mem={0x042} (add R1,R0), Done at T3 → 4 pulses, Data_Out=0x042 throughout, Finished=1, Instr_Count=1.
- mem={0x042}, Done_In tied 0 → Error=1 after 4th pulse, Finished=0, PC=0, no 5th pulse.
- mem={0x000}, Prog_Len=1 (ld with no data word) → 1 pulse then Error=1, PC=0.
- Reset asserted mid-HIGH → Step_Clock=0 same cycle (async), Busy=0, Data_Out=0. A subsequent Start reruns from PC=0 correctly.
- Prog_Len=0, Start → Finished=1 next cycle, zero pulses. Load_En during a run → memory unchanged; verify by rerun.
